// File: rtl/dnn2ami_req_arbiter_pkg.sv
// Shared AMI types for the DNN memory channel: request payload and arbiter state encoding.
package dnn2ami_req_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [47:0] addr;
        logic [63:0] data;
        logic [7:0]  size;
    } AMIRequest;

    typedef enum logic [1:0] {
        IDLE,
        OWN_RD,
        OWN_WR
    } ArbState;

endpackage

// File: rtl/dnn2ami_req_arbiter.sv
// Burst-aware round-robin arbiter sharing one AMI request port between the DNN read and write sequencers.
// Optional statistics counters are enabled with `define DNN2AMI_ARB_STATS_EN.
module dnn2ami_req_arbiter
    import dnn2ami_req_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter bit          WR_FIRST  = 1'b1,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_reqValid,
    input  AMIRequest        rd_reqOut,
    output logic             rd_reqOut_grant,
    input  logic             wr_reqValid,
    input  AMIRequest        wr_reqOut,
    output logic             wr_reqOut_grant,
    output logic             reqValid,
    output AMIRequest        reqOut,
    input  logic             reqOut_grant,
`ifdef DNN2AMI_ARB_STATS_EN
    output logic [31:0]      stat_rd_grants,
    output logic [31:0]      stat_wr_grants,
    output logic [31:0]      stat_stall_cycles,
`endif
    output logic             arb_busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    ArbState          state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             out_valid_q, out_valid_d;
    AMIRequest        out_req_q, out_req_d;

    logic load;
    logic grant_rd;
    logic grant_wr;
    logic [CNT_W-1:0] burst_inc;

    assign load      = !out_valid_q || reqOut_grant;
    assign burst_inc = (burst_cnt_q < MAX_CNT) ? burst_cnt_q + ONE_CNT : MAX_CNT;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        out_valid_d = out_valid_q;
        out_req_d   = out_req_q;

        if (load) begin
            case (state_q)
                OWN_WR: begin
                    if (wr_reqValid && (burst_cnt_q < MAX_CNT || !rd_reqValid)) grant_wr = 1'b1;
                    else if (rd_reqValid)                                       grant_rd = 1'b1;
                end
                OWN_RD: begin
                    if (rd_reqValid && (burst_cnt_q < MAX_CNT || !wr_reqValid)) grant_rd = 1'b1;
                    else if (wr_reqValid)                                       grant_wr = 1'b1;
                end
                default: begin
                    if (wr_reqValid && rd_reqValid) begin
                        grant_wr = WR_FIRST;
                        grant_rd = !WR_FIRST;
                    end else begin
                        grant_wr = wr_reqValid;
                        grant_rd = rd_reqValid;
                    end
                end
            endcase

            // Keeping the tenure extends the burst; switching or leaving IDLE restarts it at one.
            if (grant_wr) begin
                state_d     = OWN_WR;
                burst_cnt_d = (state_q == OWN_WR) ? burst_inc : ONE_CNT;
                out_req_d   = wr_reqOut;
            end else if (grant_rd) begin
                state_d     = OWN_RD;
                burst_cnt_d = (state_q == OWN_RD) ? burst_inc : ONE_CNT;
                out_req_d   = rd_reqOut;
            end else begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
            out_valid_d = grant_wr || grant_rd;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_req_q   <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_req_q   <= out_req_d;
        end
    end

    assign rd_reqOut_grant = grant_rd && !rst;
    assign wr_reqOut_grant = grant_wr && !rst;
    assign reqValid        = out_valid_q;
    assign reqOut          = out_req_q;
    assign arb_busy        = out_valid_q || rd_reqValid || wr_reqValid;

`ifdef DNN2AMI_ARB_STATS_EN
    logic [31:0] stat_rd_q, stat_rd_d;
    logic [31:0] stat_wr_q, stat_wr_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_rd_d    = stat_rd_q    + {31'd0, rd_reqOut_grant};
        stat_wr_d    = stat_wr_q    + {31'd0, wr_reqOut_grant};
        stat_stall_d = stat_stall_q + {31'd0, out_valid_q && !reqOut_grant};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_q    <= '0;
            stat_wr_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_rd_q    <= stat_rd_d;
            stat_wr_q    <= stat_wr_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_rd_grants    = stat_rd_q;
    assign stat_wr_grants    = stat_wr_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_dnn2ami_req_arbiter.sv
// Self-checking bench for dnn2ami_req_arbiter: scripted grant sequences plus a payload scoreboard.
module tb_dnn2ami_req_arbiter;
    import dnn2ami_req_arbiter_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      rd_reqValid, wr_reqValid;
    AMIRequest rd_reqOut, wr_reqOut;
    logic      rd_reqOut_grant, wr_reqOut_grant;
    logic      reqValid;
    AMIRequest reqOut;
    logic      reqOut_grant;
    logic      arb_busy;
`ifdef DNN2AMI_ARB_STATS_EN
    logic [31:0] stat_rd_grants, stat_wr_grants, stat_stall_cycles;
`endif

    dnn2ami_req_arbiter #(.MAX_BURST(4), .WR_FIRST(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_reqValid     (rd_reqValid),
        .rd_reqOut       (rd_reqOut),
        .rd_reqOut_grant (rd_reqOut_grant),
        .wr_reqValid     (wr_reqValid),
        .wr_reqOut       (wr_reqOut),
        .wr_reqOut_grant (wr_reqOut_grant),
        .reqValid        (reqValid),
        .reqOut          (reqOut),
        .reqOut_grant    (reqOut_grant),
`ifdef DNN2AMI_ARB_STATS_EN
        .stat_rd_grants    (stat_rd_grants),
        .stat_wr_grants    (stat_wr_grants),
        .stat_stall_cycles (stat_stall_cycles),
`endif
        .arb_busy        (arb_busy)
    );

    always #5 clk = ~clk;

    int        total = 0;
    int        bad   = 0;
    AMIRequest q_exp[$];
    int        rd_left = 0, wr_left = 0;
    logic [15:0] rd_seq = 16'd0, wr_seq = 16'd0;

    function automatic AMIRequest mk(input bit w, input logic [15:0] seq);
        AMIRequest r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = w;
        r.addr     = {16'h0000, (w ? 16'hA000 : 16'h5000), seq};
        r.data     = {seq, ~seq, seq ^ 16'h3C3C, 15'd0, w};
        r.size     = seq[7:0];
        return r;
    endfunction

    function automatic byte gcode();
        if (rd_reqOut_grant === 1'b1 && wr_reqOut_grant === 1'b1) return "X";
        if (wr_reqOut_grant === 1'b1) return "W";
        if (rd_reqOut_grant === 1'b1) return "R";
        return "-";
    endfunction

    task automatic drive();
        rd_reqValid = (rd_left > 0);
        wr_reqValid = (wr_left > 0);
        rd_reqOut   = mk(1'b0, rd_seq);
        wr_reqOut   = mk(1'b1, wr_seq);
    endtask

    // Called at a negedge: sources pop on grant, and the granted payload is queued for the output monitor.
    task automatic tick();
        bit g_rd, g_wr;
        g_rd = (rd_reqOut_grant === 1'b1);
        g_wr = (wr_reqOut_grant === 1'b1);
        if (g_rd) q_exp.push_back(rd_reqOut);
        if (g_wr) q_exp.push_back(wr_reqOut);
        @(posedge clk);
        #1;
        if (g_rd) begin rd_left--; rd_seq++; end
        if (g_wr) begin wr_left--; wr_seq++; end
        drive();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tick();
        end
    endtask

    task automatic stop_sources();
        rd_left = 0;
        wr_left = 0;
        drive();
        idle(3);
    endtask

    always @(negedge clk) begin
        if (!rst && reqValid === 1'b1 && reqOut_grant === 1'b1) begin
            total++;
            if (q_exp.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: reqOut=%h with no request pending", reqOut);
            end else begin
                AMIRequest e;
                e = q_exp.pop_front();
                if (reqOut !== e) begin
                    bad++;
                    $display("FAIL out_payload: got %h expected %h", reqOut, e);
                end
            end
        end
    end

    task automatic test_reset();
        #3;
        total++; if (reqValid !== 1'b0) begin bad++; $display("FAIL reset_reqValid: got %b expected 0", reqValid); end
        total++; if (reqOut !== '0) begin bad++; $display("FAIL reset_reqOut: got %h expected 0", reqOut); end
        total++; if ({rd_reqOut_grant, wr_reqOut_grant} !== 2'b00) begin
            bad++; $display("FAIL reset_grants: got %b expected 00", {rd_reqOut_grant, wr_reqOut_grant}); end
        total++; if (arb_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", arb_busy); end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 reqOut_grant = 1'b1;
    endtask

    task automatic test_lone_wr();
        string exp = "WWWWWWWWWW-";
        wr_left = 10;
        drive();
        for (int i = 0; i < exp.len(); i++) begin
            @(negedge clk);
            total++;
            if (gcode() !== exp[i]) begin bad++; $display("FAIL lone_wr_grant[%0d]: got %c expected %c", i, gcode(), exp[i]); end
            if (i == 0) begin
                total++;
                if (reqValid !== 1'b0 || arb_busy !== 1'b1) begin
                    bad++; $display("FAIL lone_wr_first: reqValid=%b arb_busy=%b expected 0 1", reqValid, arb_busy); end
            end
            if (i == 1) begin
                total++;
                if (reqValid !== 1'b1) begin bad++; $display("FAIL lone_wr_latency: reqValid=%b expected 1", reqValid); end
            end
            tick();
        end
        stop_sources();
    endtask

    task automatic test_burst();
        string exp = "WWWWRRRRWWWW";
        rd_left = 20;
        wr_left = 20;
        drive();
        for (int i = 0; i < exp.len(); i++) begin
            @(negedge clk);
            total++;
            if (gcode() !== exp[i]) begin bad++; $display("FAIL burst_grant[%0d]: got %c expected %c", i, gcode(), exp[i]); end
            tick();
        end
        stop_sources();
    endtask

    task automatic test_stall();
        AMIRequest held;
        rd_left = 20;
        wr_left = 20;
        drive();
        held = wr_reqOut;
        @(negedge clk);
        total++;
        if (gcode() !== "W") begin bad++; $display("FAIL stall_fill: got %c expected W", gcode()); end
        tick();
        reqOut_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (gcode() !== "-") begin bad++; $display("FAIL stall_grant[%0d]: got %c expected -", i, gcode()); end
            total++;
            if (reqOut !== held || reqValid !== 1'b1) begin
                bad++; $display("FAIL stall_hold[%0d]: reqValid=%b reqOut=%h expected 1 %h", i, reqValid, reqOut, held); end
            tick();
        end
        reqOut_grant = 1'b1;
        @(negedge clk);
        total++;
        if (gcode() !== "W") begin bad++; $display("FAIL stall_release: got %c expected W", gcode()); end
        tick();
        stop_sources();
    endtask

    task automatic test_owner_drop();
        string exp = "WWR";
        wr_left = 2;
        rd_left = 20;
        drive();
        for (int i = 0; i < exp.len(); i++) begin
            @(negedge clk);
            total++;
            if (gcode() !== exp[i]) begin bad++; $display("FAIL drop_grant[%0d]: got %c expected %c", i, gcode(), exp[i]); end
            tick();
        end
        total++;
        if (dut.state_q !== OWN_RD || dut.burst_cnt_q !== 3'd1) begin
            bad++; $display("FAIL drop_state: state=%0d cnt=%0d expected %0d 1", dut.state_q, dut.burst_cnt_q, OWN_RD); end
        stop_sources();
    endtask

    task automatic test_reset_mid();
        string exp = "WWWWR";
        rd_left = 20;
        wr_left = 20;
        drive();
        idle(2);
        total++;
        if (reqValid !== 1'b1) begin bad++; $display("FAIL mid_full: reqValid=%b expected 1", reqValid); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (reqValid !== 1'b0 || reqOut !== '0) begin
            bad++; $display("FAIL mid_async: reqValid=%b reqOut=%h expected 0 0", reqValid, reqOut); end
        total++;
        if ({rd_reqOut_grant, wr_reqOut_grant} !== 2'b00) begin
            bad++; $display("FAIL mid_grants: got %b expected 00", {rd_reqOut_grant, wr_reqOut_grant}); end
        q_exp.delete();
        rd_left = 0;
        wr_left = 0;
        drive();
        @(posedge clk);
        #2 rst = 1'b0;
        rd_left = 20;
        wr_left = 20;
        drive();
        for (int i = 0; i < exp.len(); i++) begin
            @(negedge clk);
            total++;
            if (gcode() !== exp[i]) begin bad++; $display("FAIL mid_grant[%0d]: got %c expected %c", i, gcode(), exp[i]); end
            tick();
        end
        stop_sources();
    endtask

`ifdef DNN2AMI_ARB_STATS_EN
    task automatic test_stats();
        string exp_rd = "RRRRRR--";
        string exp_wr = "WWWWWW";
        rst = 1'b1;
        #2 rst = 1'b0;
        q_exp.delete();
        rd_left = 6;
        drive();
        for (int i = 0; i < exp_rd.len(); i++) begin
            @(negedge clk);
            total++;
            if (gcode() !== exp_rd[i]) begin bad++; $display("FAIL stats_rd[%0d]: got %c expected %c", i, gcode(), exp_rd[i]); end
            tick();
        end
        wr_left = 6;
        drive();
        for (int i = 0; i < exp_wr.len(); i++) begin
            @(negedge clk);
            total++;
            if (gcode() !== exp_wr[i]) begin bad++; $display("FAIL stats_wr[%0d]: got %c expected %c", i, gcode(), exp_wr[i]); end
            tick();
        end
        reqOut_grant = 1'b0;
        idle(3);
        reqOut_grant = 1'b1;
        idle(2);
        total++;
        if (stat_rd_grants !== 32'd6 || stat_wr_grants !== 32'd6 || stat_stall_cycles !== 32'd3) begin
            bad++;
            $display("FAIL stats_counts: got %0d/%0d/%0d expected 6/6/3",
                     stat_rd_grants, stat_wr_grants, stat_stall_cycles);
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        reqOut_grant = 1'b0;
        drive();
        test_reset();
        test_lone_wr();
        test_burst();
        test_stall();
        test_owner_drop();
        test_reset_mid();
`ifdef DNN2AMI_ARB_STATS_EN
        test_stats();
`endif
        total++;
        if (q_exp.size() != 0) begin bad++; $display("FAIL drain: %0d requests never appeared on reqOut", q_exp.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
